viterbi_flush_injector: RTL and testbench
=========================================

Name: viterbi_flush_injector

Overview:
- Sits between the depuncturer and the Viterbi decoder, downstream of the last-symbol tracker whose last_sym_flag it consumes.
- Forwards soft-bit pairs unchanged with one cycle of latency.
- After the final OFDM symbol has drained, it injects FLUSH_LEN erased soft-bit pairs so the decoder traceback releases the tail bits early.
- Raises a one-cycle flush_done when injection completes.

Parameters:
FLUSH_LEN, 72, number of erased pairs injected after the last symbol (≥1).
GAP_CYCLES, 4, consecutive idle input cycles required after last_sym_flag before injection starts (≥1).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  FSM advance enable; pass-through unaffected
in_valid  input  1  soft-bit pair valid from depuncturer
in_a  input  3  soft bit A
in_b  input  3  soft bit B
in_erase  input  2  erasure flags {B,A}
last_sym_flag  input  1  level, high once all symbols are received; cleared only by upstream reset
out_valid  output  1  pair valid to Viterbi
out_a  output  3  soft bit A
out_b  output  3  soft bit B
out_erase  output  2  erasure flags {B,A}
flush_active  output  1  high while in S_FLUSH
flush_done  output  1  one-cycle pulse when the last flush pair is emitted

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is S_PASS.
  - gap_cnt and flush_cnt are 0.
- Datapath is registered, with 1-cycle latency.
  - in_valid=1 at cycle t gives out_valid=1 with identical a/b/erase at t+1, in every state.
  - Input always has priority over injection.
- Injected pair: out_valid=1, out_a=0, out_b=0, out_erase=2'b11.
- States:
  - S_PASS:
    - Forward input only.
    - If enable and last_sym_flag=1, go to S_ARMED and clear gap_cnt.
  - S_ARMED:
    - Forward input.
    - in_valid=1 clears gap_cnt.
    - Otherwise, if enable, gap_cnt increments.
    - When gap_cnt reaches GAP_CYCLES-1 on an idle, enabled cycle, go to S_FLUSH and clear flush_cnt.
  - S_FLUSH:
    - flush_active=1. It is registered and high in the same cycles the state is S_FLUSH.
    - Each cycle with enable=1 and in_valid=0 emits one injected pair next cycle and increments flush_cnt.
    - A cycle with in_valid=1 forwards input instead; flush_cnt is held.
    - When flush_cnt reaches FLUSH_LEN-1 on an emitting cycle, go to S_DONE.
    - flush_done pulses in the same output cycle as the final injected pair.
  - S_DONE:
    - Forward input only.
    - Stays here until reset; last_sym_flag staying high does not re-trigger.
- enable=0:
  - State, gap_cnt and flush_cnt are frozen.
  - No injection occurs.
  - Pass-through continues.
- last_sym_flag is sampled as a level. If already high out of reset, the block enters S_ARMED on the first enabled cycle.
- Counter widths: $clog2(FLUSH_LEN+1) and $clog2(GAP_CYCLES+1) bits. No wrap is possible because transitions occur at terminal counts.
- Reset mid-flush:
  - Returns to S_PASS and drops flush_active.
  - No flush_done is generated.
  - The registered output is cleared the next cycle.
- Simultaneous events:
  - In S_PASS, last_sym_flag rising together with in_valid still transitions to S_ARMED; gap_cnt starts at 0.
  - In S_ARMED, input arriving on the would-be transition cycle blocks the transition.

Decomposition:
- Shared package holds:
  - State encoding constants S_PASS=0, S_ARMED=1, S_FLUSH=2, S_DONE=3.
  - Soft-bit width constant SOFT_W=3.
  - Erasure-code constant ERASE_BOTH=2'b11.
- One natural sub-module: soft_pair_reg, the registered 2×SOFT_W+2 bit output stage with a valid/clear.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then 10 pairs with in_valid=1 and last_sym_flag=0 -> each pair appears 1 cycle later, bit-exact; no injection; flush_active=0.
- last_sym_flag high, then input idle with defaults -> injection starts 4 idle cycles after arming: exactly 72 consecutive pairs a=b=0, erase=11; flush_done high only with the 72nd pair; then S_DONE with no further pairs.
- During flush, after 10 injected pairs, drive 3 input pairs -> those 3 forwarded unchanged; injection resumes; total injected still exactly 72.
- In S_ARMED, input bursts every 3 cycles with GAP_CYCLES=4 -> never enters S_FLUSH; starts only after the bursts stop plus 4 idle cycles.
- enable=0 for 20 cycles mid-flush -> pass-through continues; no injected pairs; flush_cnt unchanged; injection completes after enable returns.
- reset asserted after 30 injected pairs -> outputs 0 next cycle; state S_PASS; no flush_done; a new last_sym_flag yields a full 72-pair flush.

Source files
------------

// File: rtl/viterbi_flush_injector_pkg.sv
// viterbi_flush_injector_pkg: shared state encoding and soft-bit constants for the flush injector
package viterbi_flush_injector_pkg;
  localparam int SOFT_W = 3;
  localparam logic [1:0] ERASE_BOTH = 2'b11;
  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_ARMED = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/viterbi_flush_injector_soft_pair_reg.sv
// viterbi_flush_injector_soft_pair_reg: registered soft-bit pair output stage, data zeroed when not valid
module viterbi_flush_injector_soft_pair_reg
  import viterbi_flush_injector_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [SOFT_W-1:0] d_a,
  input  logic [SOFT_W-1:0] d_b,
  input  logic [1:0]        d_erase,
  output logic              q_valid,
  output logic [SOFT_W-1:0] q_a,
  output logic [SOFT_W-1:0] q_b,
  output logic [1:0]        q_erase
);
  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_a     <= '0;
      q_b     <= '0;
      q_erase <= '0;
    end else begin
      q_valid <= load;
      q_a     <= load ? d_a : '0;
      q_b     <= load ? d_b : '0;
      q_erase <= load ? d_erase : '0;
    end
  end
endmodule

// File: rtl/viterbi_flush_injector.sv
// viterbi_flush_injector: forwards soft-bit pairs with one cycle latency and, once the last symbol
// has drained, injects FLUSH_LEN erased pairs so the Viterbi traceback releases the tail early
module viterbi_flush_injector
  import viterbi_flush_injector_pkg::*;
#(
  parameter int FLUSH_LEN  = 72,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [SOFT_W-1:0] in_a,
  input  logic [SOFT_W-1:0] in_b,
  input  logic [1:0]        in_erase,
  input  logic              last_sym_flag,
  output logic              out_valid,
  output logic [SOFT_W-1:0] out_a,
  output logic [SOFT_W-1:0] out_b,
  output logic [1:0]        out_erase,
  output logic              flush_active,
  output logic              flush_done
);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  state_t            state, state_next;
  logic [GW-1:0]     gap_cnt, gap_next;
  logic [FW-1:0]     flush_cnt, flush_next;
  logic              inject, load, done_next;
  logic [SOFT_W-1:0] pair_a, pair_b;
  logic [1:0]        pair_erase;
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_PASS;
      gap_cnt      <= '0;
      flush_cnt    <= '0;
      flush_active <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      state        <= state_next;
      gap_cnt      <= gap_next;
      flush_cnt    <= flush_next;
      flush_active <= state_next == S_FLUSH;
      flush_done   <= done_next;
    end
  end
  // counters and state only move on enabled cycles; input always wins over injection
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    flush_next = flush_cnt;
    if (enable) begin
      case (state)
        S_PASS: begin
          if (last_sym_flag) begin
            state_next = S_ARMED;
            gap_next   = '0;
          end
        end
        S_ARMED: begin
          if (in_valid) gap_next = '0;
          else if (gap_cnt == GAP_LAST) begin
            state_next = S_FLUSH;
            flush_next = '0;
          end else gap_next = gap_cnt + 1'b1;
        end
        S_FLUSH: begin
          if (!in_valid) begin
            flush_next = flush_cnt + 1'b1;
            if (flush_cnt == FLUSH_LAST) state_next = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    inject     = enable && !in_valid && state == S_FLUSH;
    done_next  = inject && flush_cnt == FLUSH_LAST;
    load       = in_valid || inject;
    pair_a     = in_valid ? in_a : '0;
    pair_b     = in_valid ? in_b : '0;
    pair_erase = in_valid ? in_erase : ERASE_BOTH;
  end
  viterbi_flush_injector_soft_pair_reg soft_pair_reg (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .d_a     (pair_a),
    .d_b     (pair_b),
    .d_erase (pair_erase),
    .q_valid (out_valid),
    .q_a     (out_a),
    .q_b     (out_b),
    .q_erase (out_erase)
  );
endmodule

// File: tb/tb_viterbi_flush_injector.sv
// tb_viterbi_flush_injector: directed vectors for pass-through, arming gap, flush injection,
// input preemption, enable freeze and mid-flush reset
module tb_viterbi_flush_injector;
  logic       clock = 1'b0;
  logic       reset, enable, in_valid, last_sym_flag;
  logic [2:0] in_a, in_b;
  logic [1:0] in_erase;
  logic       out_valid, flush_active, flush_done;
  logic [2:0] out_a, out_b;
  logic [1:0] out_erase;
  int vectors = 0;
  int miscompares = 0;
  int inj, bad, ndone, done_at;
  viterbi_flush_injector #(.FLUSH_LEN(72), .GAP_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_erase      (in_erase),
    .last_sym_flag (last_sym_flag),
    .out_valid     (out_valid),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_erase     (out_erase),
    .flush_active  (flush_active),
    .flush_done    (flush_done)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic v, input logic [2:0] a, input logic [2:0] b, input logic [1:0] e);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_erase = e;
    @(posedge clock);
    #1;
  endtask
  task automatic fwd(input string tag, input logic [2:0] a, input logic [2:0] b, input logic [1:0] e);
    tick(1'b1, a, b, e);
    check(tag, {23'd0, out_valid, out_a, out_b, out_erase}, {23'd0, 1'b1, a, b, e});
  endtask
  task automatic run_idle(input int n, output int n_inj, output int n_bad, output int n_done, output int d_at);
    n_inj = 0; n_bad = 0; n_done = 0; d_at = -1;
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, 3'd0, 3'd0, 2'd0);
      if (out_valid) begin
        n_inj++;
        if ({out_a, out_b, out_erase} != 8'b000_000_11) n_bad++;
      end
      if (flush_done) begin
        n_done++;
        d_at = i;
      end
    end
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick(1'b1, 3'd5, 3'd6, 2'd1);
    check(tag, {26'd0, out_valid, out_a, out_b, out_erase, flush_active, flush_done}, 32'd0);
    reset = 1'b0;
  endtask
  task automatic arm_and_gap(input string tag);
    tick(1'b0, 3'd0, 3'd0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 3'd0, 3'd0, 2'd0);
      check({tag, "_gap_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_gap_active"}, {31'd0, flush_active}, {31'd0, i == 4});
    end
  endtask
  task automatic check_flush(input string tag, input int n);
    run_idle(n, inj, bad, ndone, done_at);
    check({tag, "_count"}, inj, n);
    check({tag, "_erased"}, bad, 0);
    check({tag, "_done_n"}, ndone, 1);
    check({tag, "_done_at"}, done_at, n);
    check({tag, "_active_off"}, {31'd0, flush_active}, 32'd0);
  endtask
  initial begin
    reset = 1'b1; enable = 1'b1; last_sym_flag = 1'b0;
    tick(1'b0, 3'd0, 3'd0, 2'd0);
    tick(1'b0, 3'd0, 3'd0, 2'd0);
    check("reset_state", {26'd0, out_valid, out_a, out_b, out_erase, flush_active, flush_done}, 32'd0);
    reset = 1'b0;
    // plain pass-through, no flag
    for (int i = 0; i < 10; i++) begin
      logic [2:0] a, b;
      logic [1:0] e;
      a = 3'(i); b = 3'(7 - i); e = 2'(i);
      fwd("pass_pair", a, b, e);
      check("pass_active", {31'd0, flush_active}, 32'd0);
    end
    run_idle(6, inj, bad, ndone, done_at);
    check("pass_no_inject", inj, 0);
    // full flush with defaults
    last_sym_flag = 1'b1;
    arm_and_gap("t2");
    check_flush("t2_flush", 72);
    run_idle(10, inj, bad, ndone, done_at);
    check("t2_done_quiet", inj + ndone, 0);
    // input preempts injection mid-flush; arming coincides with a valid pair
    do_reset("t3_reset");
    fwd("t3_arm_fwd", 3'd1, 3'd2, 2'd3);
    for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 3'd0, 2'd0);
    check("t3_active", {31'd0, flush_active}, 32'd1);
    run_idle(10, inj, bad, ndone, done_at);
    check("t3_first10", inj, 10);
    check("t3_first10_done", ndone, 0);
    fwd("t3_fwd0", 3'd7, 3'd1, 2'd2);
    fwd("t3_fwd1", 3'd3, 3'd4, 2'd0);
    fwd("t3_fwd2", 3'd6, 3'd5, 2'd1);
    check("t3_still_active", {31'd0, flush_active}, 32'd1);
    check_flush("t3_rest", 62);
    // bursts in ARMED keep resetting the gap
    do_reset("t4_reset");
    tick(1'b0, 3'd0, 3'd0, 2'd0);
    for (int r = 0; r < 5; r++) begin
      tick(1'b0, 3'd0, 3'd0, 2'd0);
      tick(1'b0, 3'd0, 3'd0, 2'd0);
      check("t4_burst_idle", {30'd0, out_valid, flush_active}, 32'd0);
      fwd("t4_burst_fwd", 3'(r), 3'(r + 2), 2'(r));
      check("t4_burst_active", {31'd0, flush_active}, 32'd0);
    end
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 3'd0, 3'd0, 2'd0);
      check("t4_gap_active", {31'd0, flush_active}, {31'd0, i == 4});
    end
    // enable low mid-flush freezes injection but not pass-through
    run_idle(5, inj, bad, ndone, done_at);
    check("t5_first5", inj, 5);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) fwd("t5_frozen_fwd", 3'(i), 3'(i + 3), 2'(i));
      else begin
        tick(1'b0, 3'd0, 3'd0, 2'd0);
        check("t5_frozen_idle", {31'd0, out_valid}, 32'd0);
      end
      check("t5_frozen_active", {31'd0, flush_active}, 32'd1);
    end
    enable = 1'b1;
    check_flush("t5_rest", 67);
    // reset after 30 injected pairs, then a fresh flush
    do_reset("t6_reset0");
    arm_and_gap("t6a");
    run_idle(30, inj, bad, ndone, done_at);
    check("t6_first30", inj, 30);
    do_reset("t6_midreset");
    last_sym_flag = 1'b0;
    run_idle(8, inj, bad, ndone, done_at);
    check("t6_idle_after_reset", inj + ndone, 0);
    check("t6_state_pass", {31'd0, flush_active}, 32'd0);
    last_sym_flag = 1'b1;
    arm_and_gap("t6b");
    check_flush("t6_flush", 72);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
